// File: rtl/dcache_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_lsu_if
// Desc     : Word-wide request/acknowledge data memory bus between LSU and memory.
// Revision : 1.0
// ============================================================================
interface dcache_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dcache_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dcache_lsu
// Desc     : Memory-stage load/store unit: one bus transaction per access, byte
//            strobes, load extension, bus timeout. DCACHE_MISALIGN_TRAP_EN traps
//            misaligned half/word accesses instead of aligning them down.
// Revision : 1.0
// ============================================================================
module dcache_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic         ren,
  input  logic [2:0]   rwidth,
  input  logic         rsign,
  input  logic         wen,
  input  logic [2:0]   wwidth,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  dcache_lsu_if.master bus,
  output logic         stall,
  output logic         done,
  output logic [31:0]  rdata,
  output logic         access_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] c_tc_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [2:0]  r_width;
  logic        r_sign;
  logic [7:0]  r_tcnt;

  logic        w_req;
  logic        w_legal;
  logic        w_width_ok;
  logic [2:0]  w_width;
  logic [1:0]  w_lane;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  assign w_req      = req_valid && (ren || wen);
  assign w_width    = wen ? wwidth : rwidth;
  assign w_width_ok = (w_width == 3'd1) || (w_width == 3'd2) || (w_width == 3'd4);

`ifdef DCACHE_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_width == 3'd2) && addr[0]) ||
                      ((w_width == 3'd4) && (addr[1:0] != 2'b00));
  // Any request that survives the trap is already naturally aligned.
  assign w_lane     = addr[1:0];
  assign w_legal    = (ren ^ wen) && w_width_ok && !w_misalign;
`else
  assign w_lane     = (w_width == 3'd4) ? 2'b00 :
                      (w_width == 3'd2) ? {addr[1], 1'b0} : addr[1:0];
  assign w_legal    = (ren ^ wen) && w_width_ok;
`endif

  always_comb begin
    w_strb      = 4'b1111;
    w_wdata_rep = wdata;
    case (w_width)
      3'd1: begin
        w_strb      = 4'b0001 << w_lane;
        w_wdata_rep = {4{wdata[7:0]}};
      end
      3'd2: begin
        w_strb      = 4'b0011 << w_lane;
        w_wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend.
  assign w_shifted = bus.mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_width)
      3'd1:    w_load = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
      3'd2:    w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  assign stall = ((r_state == S_IDLE) && w_req && w_legal) ||
                 ((r_state == S_BUSY) && !bus.mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lane        <= 2'b00;
      r_width       <= 3'd0;
      r_sign        <= 1'b0;
      r_tcnt        <= 8'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wstrb <= 4'd0;
      bus.mem_wdata <= 32'd0;
      done          <= 1'b0;
      access_err    <= 1'b0;
      rdata         <= 32'd0;
    end else begin
      done       <= 1'b0;
      access_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_legal) begin
              r_state       <= S_BUSY;
              r_lane        <= w_lane;
              r_width       <= w_width;
              r_sign        <= rsign;
              r_tcnt        <= 8'd0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= wen;
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wstrb <= wen ? w_strb : 4'b0000;
              bus.mem_wdata <= w_wdata_rep;
            end else begin
              access_err <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          // Ack is tested first so an ack on the expiry cycle still completes.
          if (bus.mem_ack) begin
            r_state     <= S_IDLE;
            bus.mem_req <= 1'b0;
            done        <= 1'b1;
            if (!bus.mem_we) begin
              rdata <= w_load;
            end
          end else if (r_tcnt == c_tc_last) begin
            r_state     <= S_IDLE;
            bus.mem_req <= 1'b0;
            access_err  <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
